// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the execute-stage ALU.
// Holds the ALU operation codes (decoder encoding), the FSM state encoding
// and the default operand / shift-amount widths.
package alu_exec_unit_pkg;

  localparam int unsigned DataWidthDflt  = 32;
  localparam int unsigned ShamtWidthDflt = 5;

  // Operation codes as produced by the ALU control decoder.
  localparam logic [3:0] OpSll = 4'b0000;
  localparam logic [3:0] OpSrl = 4'b0001;
  localparam logic [3:0] OpLui = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0011;
  localparam logic [3:0] OpSub = 4'b0100;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpNor = 4'b0111;
  localparam logic [3:0] OpOr  = 4'b1000;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OpSll) || (op == OpSrl);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OpSll) || (op == OpSrl) || (op == OpLui) || (op == OpAdd) ||
           (op == OpSub) || (op == OpAnd) || (op == OpNor) || (op == OpOr);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: one bit position per cycle.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_load            load i_data / i_shamt / i_dir_left
//   i_dir_left        1 = shift left (SLL), 0 = logical right (SRL)
//   i_data, i_shamt   value to shift and number of positions
//   o_data_next       register contents after one more shift step
//   o_busy            shift positions remain
//   o_last            exactly one position remains
module alu_serial_shifter
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DataWidthDflt,
  parameter int unsigned SHAMT_WIDTH = ShamtWidthDflt
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load,
  input  logic                   i_dir_left,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic [SHAMT_WIDTH-1:0] i_shamt,
  output logic [DATA_WIDTH-1:0]  o_data_next,
  output logic                   o_busy,
  output logic                   o_last
);

  logic [DATA_WIDTH-1:0]  r_data;
  logic [SHAMT_WIDTH-1:0] r_cnt;
  logic                   r_dir_left;
  logic [DATA_WIDTH-1:0]  w_data_next;

  always_comb begin
    w_data_next = r_dir_left ? {r_data[DATA_WIDTH-2:0], 1'b0} : {1'b0, r_data[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data     <= '0;
      r_cnt      <= '0;
      r_dir_left <= 1'b0;
    end else if (i_load) begin
      r_data     <= i_data;
      r_cnt      <= i_shamt;
      r_dir_left <= i_dir_left;
    end else if (r_cnt != '0) begin
      r_data <= w_data_next;
      r_cnt  <= r_cnt - SHAMT_WIDTH'(1);
    end
  end

  assign o_data_next = w_data_next;
  assign o_busy      = (r_cnt != '0);
  assign o_last      = (r_cnt == SHAMT_WIDTH'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake and registered outputs.
// Single-cycle: LUI, ADD, SUB, AND, NOR, OR, illegal codes, zero-length shifts.
// Multi-cycle: SLL/SRL with shamt != 0, one bit per cycle in alu_serial_shifter.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        operation handshake (ready only when idle)
//   alu_operation, a, b, shamt operation code and operands
//   out_valid / out_ready      result handshake
//   result, zero, illegal_op   registered outputs, valid while out_valid
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DataWidthDflt,
  parameter int unsigned SHAMT_WIDTH = ShamtWidthDflt
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             alu_operation,
  input  logic [DATA_WIDTH-1:0]  a,
  input  logic [DATA_WIDTH-1:0]  b,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   zero,
  output logic                   illegal_op
);

  localparam int unsigned HalfW = DATA_WIDTH / 2;

  state_e                r_state, w_state_d;
  logic [DATA_WIDTH-1:0] r_result, w_result_d;
  logic                  r_zero, w_zero_d;
  logic                  r_illegal, w_illegal_d;

  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_shift_load;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  w_shift_busy;
  logic                  w_shift_last;

  // Single-cycle datapath. Shift cases only matter for shamt == 0 here.
  always_comb begin
    w_alu_result = '0;
    case (alu_operation)
      OpSll:   w_alu_result = b << shamt;
      OpSrl:   w_alu_result = b >> shamt;
      OpLui:   w_alu_result = {b[HalfW-1:0], {HalfW{1'b0}}};
      OpAdd:   w_alu_result = a + b;
      OpSub:   w_alu_result = a - b;
      OpAnd:   w_alu_result = a & b;
      OpNor:   w_alu_result = ~(a | b);
      OpOr:    w_alu_result = a | b;
      default: w_alu_result = '0;
    endcase
  end

  alu_serial_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_shifter (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_load     (w_shift_load),
    .i_dir_left (alu_operation == OpSll),
    .i_data     (b),
    .i_shamt    (shamt),
    .o_data_next(w_shift_next),
    .o_busy     (w_shift_busy),
    .o_last     (w_shift_last)
  );

  always_comb begin
    w_state_d    = r_state;
    w_result_d   = r_result;
    w_zero_d     = r_zero;
    w_illegal_d  = r_illegal;
    w_shift_load = 1'b0;
    case (r_state)
      StIdle: begin
        if (in_valid) begin
          if (is_shift_op(alu_operation) && (shamt != '0)) begin
            w_shift_load = 1'b1;
            w_state_d    = StShift;
          end else begin
            w_result_d  = w_alu_result;
            w_zero_d    = (w_alu_result == '0);
            w_illegal_d = !is_legal_op(alu_operation);
            w_state_d   = StDone;
          end
        end
      end
      StShift: begin
        // Final step: capture the value the shifter is about to produce.
        if (w_shift_busy && w_shift_last) begin
          w_result_d  = w_shift_next;
          w_zero_d    = (w_shift_next == '0);
          w_illegal_d = 1'b0;
          w_state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_result  <= w_result_d;
      r_zero    <= w_zero_d;
      r_illegal <= w_illegal_d;
    end
  end

  assign in_ready   = (r_state == StIdle);
  assign out_valid  = (r_state == StDone);
  assign result     = r_result;
  assign zero       = r_zero;
  assign illegal_op = r_illegal;

endmodule
